uart_sram_loader: RTL and testbench

UART_SRAM_LOADER -- requirements
Module: uart_sram_loader

---
 rtl/uart_sram_loader_pkg.sv | 34 +++
 rtl/uart_sram_loader_uart_rx.sv | 99 +++++++++
 rtl/uart_sram_loader.sv | 195 +++++++++++++++++++
 tb/tb_uart_sram_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sram_loader_pkg.sv
// uart_sram_loader_pkg
//   Shared definitions for the UART-to-SRAM loader: loader FSM state
//   encoding, receiver state encoding, the END opcode nibble and the
//   SRAM word-address width.
//   Optional feature macro: LOADER_CKSUM_EN (checksum byte after END).
package uart_sram_loader_pkg;

   localparam int         SRAM_AW    = 18;
   localparam logic [3:0] END_NIBBLE = 4'b0000;

   typedef enum logic [2:0] {
      ST_WAIT_HI  = 3'd0,
      ST_WAIT_LO  = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4,
      ST_WAIT_CK  = 3'd5,
      ST_DONE     = 3'd6,
      ST_ERR      = 3'd7
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // A word whose top nibble is the END opcode terminates the load.
   function automatic logic is_end_word(input logic [15:0] w);
      return w[15:12] == END_NIBBLE;
   endfunction

endpackage

// File: rtl/uart_sram_loader_uart_rx.sv
// uart_rx
//   8N1 UART receiver, LSB first, oversampling with a cycle counter.
//   Ports:
//     CLK, RST_N  - clock, synchronous active-low reset
//     rxd         - asynchronous serial input (idle high)
//     rx_byte     - last received byte, valid with byte_valid
//     byte_valid  - one-cycle pulse per good byte
//     frame_err   - one-cycle pulse when the stop bit samples low
//   Parameter BIT_CYC: clock cycles per bit, supplied by the loader.
module uart_rx
   import uart_sram_loader_pkg::*;
#(
   parameter int BIT_CYC = 434
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int             CW      = $clog2(BIT_CYC + 1);
   localparam logic [CW-1:0]  HALF_M1 = CW'(BIT_CYC / 2 - 1);
   localparam logic [CW-1:0]  FULL_M1 = CW'(BIT_CYC - 1);

   rx_state_t     state;
   logic          sync1, sync2, prev;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         // Synchronizer loads idle level so reset never fakes a start edge.
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         prev       <= 1'b1;
         state      <= RX_IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync1      <= rxd;
         sync2      <= sync1;
         prev       <= sync2;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (prev && !sync2) begin
                  state <= RX_START;
                  cnt   <= '0;
               end
            end
            RX_START: begin
               // Re-check the start bit at mid-bit; a high line was a glitch.
               if (cnt == HALF_M1) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  shreg <= {sync2, shreg[7:1]};
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) state <= RX_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               // Return to idle at mid-stop so the next start edge is caught.
               if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  state <= RX_IDLE;
                  if (sync2) begin
                     rx_byte    <= shreg;
                     byte_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_sram_loader.sv
// uart_sram_loader
//   Receives big-endian 16-bit words over UART and writes them to
//   consecutive SRAM word addresses from 0, holding the CPU until a word
//   with the END opcode nibble has been written.
//   Ports:
//     CLK, RST_N                  - clock, synchronous active-low reset
//     UART_RXD                    - serial input, 8N1
//     SRAM_CE/OE/LB/UB            - constant SRAM controls (0,1,0,0)
//     SRAM_WE                     - active-low write strobe
//     SRAM_A, SRAM_D, SRAM_D_OE   - word address, write data, bus drive
//     CPU_HOLD                    - high while loading or after an error
//     LOAD_DONE, LOAD_ERR         - sticky status
//     LED_G                       - low 8 bits of the written-word count
//   Optional feature macro: LOADER_CKSUM_EN - after END, one more byte must
//   equal the XOR of all preceding load bytes.
module uart_sram_loader
   import uart_sram_loader_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               UART_RXD,
   output logic               SRAM_CE,
   output logic               SRAM_OE,
   output logic               SRAM_LB,
   output logic               SRAM_UB,
   output logic               SRAM_WE,
   output logic [SRAM_AW-1:0] SRAM_A,
   output logic [15:0]        SRAM_D,
   output logic               SRAM_D_OE,
   output logic               CPU_HOLD,
   output logic               LOAD_DONE,
   output logic               LOAD_ERR,
   output logic [7:0]         LED_G
);

   localparam int                 BIT_CYC  = CLK_HZ / BAUD;
   localparam logic [SRAM_AW-1:0] ADDR_MAX = '1;

   logic [7:0]         rx_byte;
   logic               byte_valid, frame_err;

   loader_state_t      state;
   logic [SRAM_AW-1:0] addr;
   logic [7:0]         word_cnt;   // only the low byte is ever observable
   logic [7:0]         word_hi;
   logic               pulse_cnt;
`ifdef LOADER_CKSUM_EN
   logic [7:0]         cksum;
`endif

   assign SRAM_CE = 1'b0;
   assign SRAM_OE = 1'b1;
   assign SRAM_LB = 1'b0;
   assign SRAM_UB = 1'b0;
   assign SRAM_A  = addr;
   assign LED_G   = word_cnt;

   uart_rx #(.BIT_CYC(BIT_CYC)) u_rx (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .rxd       (UART_RXD),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .frame_err (frame_err)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= ST_WAIT_HI;
         addr      <= '0;
         word_cnt  <= '0;
         word_hi   <= '0;
         pulse_cnt <= 1'b0;
         SRAM_WE   <= 1'b1;
         SRAM_D_OE <= 1'b0;
         SRAM_D    <= '0;
         CPU_HOLD  <= 1'b1;
         LOAD_DONE <= 1'b0;
         LOAD_ERR  <= 1'b0;
`ifdef LOADER_CKSUM_EN
         cksum     <= '0;
`endif
      end else begin
         case (state)
            ST_WAIT_HI: begin
               if (frame_err) begin
                  state    <= ST_ERR;
                  LOAD_ERR <= 1'b1;
               end else if (byte_valid) begin
                  word_hi <= rx_byte;
                  state   <= ST_WAIT_LO;
`ifdef LOADER_CKSUM_EN
                  cksum   <= cksum ^ rx_byte;
`endif
               end
            end
            ST_WAIT_LO: begin
               if (frame_err) begin
                  state    <= ST_ERR;
                  LOAD_ERR <= 1'b1;
               end else if (byte_valid) begin
                  // Data and drive enable go valid one cycle ahead of WE.
                  SRAM_D    <= {word_hi, rx_byte};
                  SRAM_D_OE <= 1'b1;
                  state     <= ST_WR_SETUP;
`ifdef LOADER_CKSUM_EN
                  cksum     <= cksum ^ rx_byte;
`endif
               end
            end
            ST_WR_SETUP: begin
               if (byte_valid) begin
                  state     <= ST_ERR;
                  LOAD_ERR  <= 1'b1;
                  SRAM_D_OE <= 1'b0;
               end else begin
                  SRAM_WE   <= 1'b0;
                  pulse_cnt <= 1'b0;
                  state     <= ST_WR_PULSE;
               end
            end
            ST_WR_PULSE: begin
               if (byte_valid) begin
                  state     <= ST_ERR;
                  LOAD_ERR  <= 1'b1;
                  SRAM_WE   <= 1'b1;
                  SRAM_D_OE <= 1'b0;
               end else if (pulse_cnt) begin
                  SRAM_WE <= 1'b1;
                  state   <= ST_WR_HOLD;
               end else begin
                  pulse_cnt <= 1'b1;
               end
            end
            ST_WR_HOLD: begin
               SRAM_D_OE <= 1'b0;
               if (byte_valid) begin
                  state    <= ST_ERR;
                  LOAD_ERR <= 1'b1;
               end else begin
                  word_cnt <= word_cnt + 8'd1;
                  if (is_end_word(SRAM_D)) begin
                     // Address saturates rather than wrapping to 0.
                     if (addr != ADDR_MAX) addr <= addr + 1'b1;
`ifdef LOADER_CKSUM_EN
                     state <= ST_WAIT_CK;
`else
                     state     <= ST_DONE;
                     LOAD_DONE <= 1'b1;
                     CPU_HOLD  <= 1'b0;
`endif
                  end else if (addr == ADDR_MAX) begin
                     // No room for anything after the last word.
                     state    <= ST_ERR;
                     LOAD_ERR <= 1'b1;
                  end else begin
                     addr  <= addr + 1'b1;
                     state <= ST_WAIT_HI;
                  end
               end
            end
`ifdef LOADER_CKSUM_EN
            ST_WAIT_CK: begin
               if (frame_err) begin
                  state    <= ST_ERR;
                  LOAD_ERR <= 1'b1;
               end else if (byte_valid) begin
                  if (rx_byte == cksum) begin
                     state     <= ST_DONE;
                     LOAD_DONE <= 1'b1;
                     CPU_HOLD  <= 1'b0;
                  end else begin
                     state    <= ST_ERR;
                     LOAD_ERR <= 1'b1;
                  end
               end
            end
`endif
            ST_DONE: state <= ST_DONE;
            ST_ERR:  state <= ST_ERR;
            default: begin
               state     <= ST_ERR;
               LOAD_ERR  <= 1'b1;
               CPU_HOLD  <= 1'b1;
               SRAM_WE   <= 1'b1;
               SRAM_D_OE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_sram_loader.sv
// tb_uart_sram_loader
//   Directed bench: UART byte streams with hand-computed SRAM writes and
//   status. A negedge monitor records each write burst (address, data,
//   D_OE length, WE-low length, A/D stability).
module tb_uart_sram_loader;

   localparam int CLK_HZ  = 50000000;
   localparam int BAUD    = 115200;
   localparam int BIT_CYC = CLK_HZ / BAUD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rxd = 1'b1;
   logic        sram_ce, sram_oe, sram_lb, sram_ub, sram_we, sram_d_oe;
   logic [17:0] sram_a;
   logic [15:0] sram_d;
   logic        cpu_hold, load_done, load_err;
   logic [7:0]  led_g;

   always #10 clk = ~clk;

   uart_sram_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .UART_RXD (rxd),
      .SRAM_CE  (sram_ce),
      .SRAM_OE  (sram_oe),
      .SRAM_LB  (sram_lb),
      .SRAM_UB  (sram_ub),
      .SRAM_WE  (sram_we),
      .SRAM_A   (sram_a),
      .SRAM_D   (sram_d),
      .SRAM_D_OE(sram_d_oe),
      .CPU_HOLD (cpu_hold),
      .LOAD_DONE(load_done),
      .LOAD_ERR (load_err),
      .LED_G    (led_g)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---- write monitor ----
   int          n_wr = 0;
   logic [17:0] wr_a   [16];
   logic [15:0] wr_d   [16];
   int          wr_oe  [16];
   int          wr_we  [16];
   logic        wr_stab[16];
   logic        in_wr = 1'b0;
   logic [17:0] cur_a;
   logic [15:0] cur_d;
   int          oe_n, we_n;
   logic        stab;

   always @(negedge clk) begin
      if (sram_d_oe) begin
         if (!in_wr) begin
            in_wr = 1'b1;
            cur_a = sram_a;
            cur_d = sram_d;
            oe_n  = 1;
            we_n  = sram_we ? 0 : 1;
            stab  = 1'b1;
         end else begin
            oe_n++;
            if (!sram_we) we_n++;
            if (sram_a != cur_a || sram_d != cur_d) stab = 1'b0;
         end
      end else if (in_wr) begin
         in_wr = 1'b0;
         wr_a[n_wr % 16]    = cur_a;
         wr_d[n_wr % 16]    = cur_d;
         wr_oe[n_wr % 16]   = oe_n;
         wr_we[n_wr % 16]   = we_n;
         wr_stab[n_wr % 16] = stab;
         n_wr++;
      end
   end

   // ---- stimulus helpers ----
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      tick(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(BIT_CYC);
      end
      rxd = stop;
      tick(BIT_CYC);
      rxd = 1'b1;
      tick(8);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic check_write(input string tag, input int k, input logic [17:0] a, input logic [15:0] d);
      check({tag, ".A"},    32'(wr_a[k % 16]), 32'(a));
      check({tag, ".D"},    32'(wr_d[k % 16]), 32'(d));
      check({tag, ".oe"},   32'(wr_oe[k % 16]), 32'd4);
      check({tag, ".we"},   32'(wr_we[k % 16]), 32'd2);
      check({tag, ".stab"}, 32'(wr_stab[k % 16]), 32'd1);
   endtask

   int base;

   initial begin
      // Reset state, sampled while reset is held
      rst_n = 1'b0;
      tick(3);
      check("rst.we",   32'(sram_we), 32'd1);
      check("rst.d_oe", 32'(sram_d_oe), 32'd0);
      check("rst.a",    32'(sram_a), 32'd0);
      check("rst.d",    32'(sram_d), 32'd0);
      check("rst.stat", 32'({cpu_hold, load_done, load_err}), 32'b100);
      check("rst.led",  32'(led_g), 32'd0);
      check("rst.ctl",  32'({sram_ce, sram_oe, sram_lb, sram_ub}), 32'b0100);
      rst_n = 1'b1;
      tick(2);

      // Normal load: 90 01 10 60 00 00
      base = n_wr;
      send_byte(8'h90, 1'b1);
      send_byte(8'h01, 1'b1);
      check("load.hold_mid", 32'(cpu_hold), 32'd1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h60, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
`ifdef LOADER_CKSUM_EN
      check("load.done_preck", 32'(load_done), 32'd0);
      send_byte(8'hE1, 1'b1);   // 90^01^10^60^00^00
`endif
      tick(10);
      check("load.nwr", 32'(n_wr - base), 32'd3);
      check_write("load.w0", base + 0, 18'h0, 16'h9001);
      check_write("load.w1", base + 1, 18'h1, 16'h1060);
      check_write("load.w2", base + 2, 18'h2, 16'h0000);
      check("load.stat", 32'({cpu_hold, load_done, load_err}), 32'b010);
      check("load.led",  32'(led_g), 32'd3);
      check("load.idle", 32'({sram_we, sram_d_oe}), 32'b10);

      // Framing error on the first byte
      do_reset();
      base = n_wr;
      send_byte(8'h90, 1'b0);
      tick(10);
      check("frm.stat", 32'({cpu_hold, load_done, load_err}), 32'b101);
      check("frm.nwr",  32'(n_wr - base), 32'd0);
      check("frm.we",   32'(sram_we), 32'd1);

      // 200-cycle low glitch, then a real pair must still pair up cleanly
      do_reset();
      base = n_wr;
      rxd = 1'b0;
      tick(200);
      rxd = 1'b1;
      tick(BIT_CYC);
      check("gl.stat", 32'({cpu_hold, load_done, load_err}), 32'b100);
      send_byte(8'h12, 1'b1);
      check("gl.nwr0", 32'(n_wr - base), 32'd0);
      send_byte(8'h34, 1'b1);
      tick(10);
      check("gl.nwr", 32'(n_wr - base), 32'd1);
      check_write("gl.w0", base, 18'h0, 16'h1234);
      check("gl.led", 32'(led_g), 32'd1);

      // Reset after 0x90 and mid-byte: both must be forgotten
      do_reset();
      send_byte(8'h90, 1'b1);
      rxd = 1'b0;
      tick(4 * BIT_CYC);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      rxd = 1'b1;
      tick(BIT_CYC);
      check("mr.stat", 32'({cpu_hold, load_done, load_err}), 32'b100);
      base = n_wr;
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      tick(10);
      check("mr.nwr", 32'(n_wr - base), 32'd1);
      check_write("mr.w0", base, 18'h0, 16'h1234);

`ifdef LOADER_CKSUM_EN
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      tick(10);
      check("ck.ok", 32'({cpu_hold, load_done, load_err}), 32'b010);
      do_reset();
      base = n_wr;
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h5A, 1'b1);
      tick(10);
      check("ck.bad", 32'({cpu_hold, load_done, load_err}), 32'b101);
      check("ck.nwr", 32'(n_wr - base), 32'd1);
`else
      // Immediate END word completes the load
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      tick(10);
      check("end.stat", 32'({cpu_hold, load_done, load_err}), 32'b010);
      check("end.led",  32'(led_g), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
